ir_field_stage: RTL and testbench

Instruction-register stage for the LC-3b datapath. It accepts fetched instruction words and their PC through a valid/ready handshake and buffers them in a 2-entry FIFO. Decode is done on entry: opcode, register specifiers and the raw immediate field are extracted and registered. The stage sits directly upstream of the sign-extension units, which take `out_imm[W-1:0]` for their configured width W (5, 6, 9, 11), and of register-file read and address generation.

---
 rtl/ir_field_stage_if.sv | 31 +++
 rtl/ir_field_stage.sv | 149 ++++++++++++++
 tb/tb_ir_field_stage.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_field_stage_if.sv
// Instruction-beat handshake bundle for the IR field stage.
// The upstream fetch side and the downstream decode consumers share one interface instance.
interface ir_field_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [3:0]  out_opcode;
    logic [2:0]  out_dr;
    logic [2:0]  out_sr1;
    logic [2:0]  out_sr2;
    logic [2:0]  out_imm_sel;
    logic [10:0] out_imm;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_opcode,
               out_dr, out_sr1, out_sr2, out_imm_sel, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_opcode,
               out_dr, out_sr1, out_sr2, out_imm_sel, out_imm, out_illegal
    );
endinterface

// File: rtl/ir_field_stage.sv
// LC-3b instruction-register stage: 2-entry FIFO with decode-on-push and a
// registered head view, plus a saturating counter of downstream stall cycles.
module ir_field_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_50,
    input  logic                   reset,
    input  logic                   flush,
    ir_field_stage_if.slave        bus,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [3:0]  opcode;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  imm_sel;
        logic [10:0] imm;
        logic        illegal;
    } entry_t;

    entry_t [1:0]           slot_q, slot_d;
    entry_t                 out_q, out_d;
    entry_t                 in_dec;
    logic                   head_q, head_d;
    logic                   tail_q, tail_d;
    logic [1:0]             count_q, count_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   push;
    logic                   pop;

    always_comb begin
        in_dec         = '0;
        in_dec.instr   = bus.in_instr;
        in_dec.pc      = bus.in_pc;
        in_dec.opcode  = bus.in_instr[15:12];
        in_dec.dr      = bus.in_instr[11:9];
        in_dec.sr1     = bus.in_instr[8:6];
        in_dec.sr2     = bus.in_instr[2:0];
        in_dec.illegal = (bus.in_instr[15:13] == 3'b101);
        case (bus.in_instr[15:12])
            4'b0001, 4'b0101, 4'b1001: begin
                // Register-mode ALU ops carry no immediate.
                if (bus.in_instr[5]) begin
                    in_dec.imm_sel = 3'd1;
                    in_dec.imm     = {6'b0, bus.in_instr[4:0]};
                end
            end
            4'b0010, 4'b0011, 4'b0110, 4'b0111: begin
                in_dec.imm_sel = 3'd2;
                in_dec.imm     = {5'b0, bus.in_instr[5:0]};
            end
            4'b0000, 4'b1110: begin
                in_dec.imm_sel = 3'd3;
                in_dec.imm     = {2'b0, bus.in_instr[8:0]};
            end
            4'b0100: begin
                if (bus.in_instr[11]) begin
                    in_dec.imm_sel = 3'd4;
                    in_dec.imm     = bus.in_instr[10:0];
                end
            end
            4'b1111: begin
                in_dec.imm_sel = 3'd5;
                in_dec.imm     = {3'b0, bus.in_instr[7:0]};
            end
            4'b1101: begin
                in_dec.imm_sel = 3'd6;
                in_dec.imm     = {7'b0, bus.in_instr[3:0]};
            end
            default: begin
                in_dec.imm_sel = 3'd0;
                in_dec.imm     = '0;
            end
        endcase
    end

    assign push = bus.in_valid && (count_q != 2'd2);
    assign pop  = (count_q != 2'd0) && bus.out_ready;

    always_comb begin
        slot_d  = slot_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        out_d   = out_q;
        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                slot_d[tail_q] = in_dec;
                tail_d         = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            // The head view is refreshed only when something remains, so an
            // empty stage keeps showing the last entry it presented.
            if (count_d != 2'd0) begin
                out_d = slot_d[head_d];
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if ((count_q != 2'd0) && !bus.out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            slot_q  <= '0;
            out_q   <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            stall_q <= '0;
        end else begin
            slot_q  <= slot_d;
            out_q   <= out_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready    = (count_q != 2'd2);
    assign bus.out_valid   = (count_q != 2'd0);
    assign bus.out_instr   = out_q.instr;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_opcode  = out_q.opcode;
    assign bus.out_dr      = out_q.dr;
    assign bus.out_sr1     = out_q.sr1;
    assign bus.out_sr2     = out_q.sr2;
    assign bus.out_imm_sel = out_q.imm_sel;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_illegal = out_q.illegal;
    assign stall_cnt       = stall_q;

endmodule

// File: tb/tb_ir_field_stage.sv
// Bench for ir_field_stage: queue-based reference model checked every cycle,
// plus directed beats with hand-computed decode results.
module tb_ir_field_stage;

    localparam int SW = 4;

    logic          clk_50 = 1'b0;
    logic          reset  = 1'b1;
    logic          flush  = 1'b0;
    logic [SW-1:0] stall_cnt;

    ir_field_stage_if bus();

    ir_field_stage #(.STALL_CNT_W(SW)) dut (
        .clk_50    (clk_50),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk_50 = ~clk_50;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } beat_t;

    beat_t       q[$];
    int          m_stall    = 0;
    bit          last_zero  = 1'b1;
    logic [15:0] last_instr = '0;
    logic [15:0] last_pc    = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediate class and field width straight from the LC-3b encoding table.
    function automatic logic [59:0] model_fields(input logic [15:0] i, input logic [15:0] pc);
        int          sel;
        int          w;
        logic [3:0]  op;
        logic [15:0] imm;
        op = i[15:12];
        case (op)
            4'd1, 4'd5, 4'd9:        sel = i[5] ? 1 : 0;
            4'd2, 4'd3, 4'd6, 4'd7:  sel = 2;
            4'd0, 4'd14:             sel = 3;
            4'd4:                    sel = i[11] ? 4 : 0;
            4'd15:                   sel = 5;
            4'd13:                   sel = 6;
            default:                 sel = 0;
        endcase
        case (sel)
            1: w = 5;
            2: w = 6;
            3: w = 9;
            4: w = 11;
            5: w = 8;
            6: w = 4;
            default: w = 0;
        endcase
        imm = i & 16'((32'd1 << w) - 1);
        return {i, pc, op, i[11:9], i[8:6], i[2:0], 3'(sel), imm[10:0], (op == 4'd10 || op == 4'd11)};
    endfunction

    always @(posedge clk_50 or posedge reset) begin
        bit pu;
        bit po;
        if (reset) begin
            q.delete();
            m_stall   = 0;
            last_zero = 1'b1;
        end else begin
            pu = bus.in_valid && (q.size() < 2);
            po = (q.size() > 0) && bus.out_ready;
            if (q.size() > 0 && !bus.out_ready && m_stall < (1 << SW) - 1) m_stall++;
            if (flush) begin
                q.delete();
            end else begin
                if (po) void'(q.pop_front());
                if (pu) q.push_back('{bus.in_instr, bus.in_pc});
            end
            if (q.size() > 0) begin
                last_instr = q[0].instr;
                last_pc    = q[0].pc;
                last_zero  = 1'b0;
            end
        end
    end

    always @(negedge clk_50) begin
        logic [59:0] act;
        logic [59:0] exp;
        if (!reset) begin
            act = {bus.out_instr, bus.out_pc, bus.out_opcode, bus.out_dr, bus.out_sr1,
                   bus.out_sr2, bus.out_imm_sel, bus.out_imm, bus.out_illegal};
            if (q.size() > 0)   exp = model_fields(q[0].instr, q[0].pc);
            else if (last_zero) exp = '0;
            else                exp = model_fields(last_instr, last_pc);
            chk("m_out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
            chk("m_in_ready", 64'(bus.in_ready), 64'(q.size() != 2));
            chk("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
            chk("m_head_fields", 64'(act), 64'(exp));
        end
    end

    task automatic step();
        @(posedge clk_50);
        #2;
    endtask

    task automatic single(input logic [15:0] instr, input logic [2:0] sel,
                          input logic [10:0] imm, input logic ill);
        bus.in_valid  = 1'b1;
        bus.in_instr  = instr;
        bus.in_pc     = 16'h3100;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("sweep_sel", 64'(bus.out_imm_sel), 64'(sel));
        chk("sweep_imm", 64'(bus.out_imm), 64'(imm));
        chk("sweep_illegal", 64'(bus.out_illegal), 64'(ill));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
        #9 reset = 1'b0;
        step();

        // Single ADD R6,R5,#-1
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h1D7F;
        bus.in_pc    = 16'h3000;
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("add_valid", 64'(bus.out_valid), 64'd1);
        chk("add_opcode", 64'(bus.out_opcode), 64'd1);
        chk("add_dr", 64'(bus.out_dr), 64'd6);
        chk("add_sr1", 64'(bus.out_sr1), 64'd5);
        chk("add_sel", 64'(bus.out_imm_sel), 64'd1);
        chk("add_imm", 64'(bus.out_imm), 64'h01F);
        chk("add_pc", 64'(bus.out_pc), 64'h3000);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        #1;
        chk("add_popped", 64'(bus.out_valid), 64'd0);

        // Opcode sweep
        single(16'h0E03, 3'd3, 11'h003, 1'b0);
        single(16'h4FFF, 3'd4, 11'h7FF, 1'b0);
        single(16'h4180, 3'd0, 11'h000, 1'b0);
        single(16'hF025, 3'd5, 11'h025, 1'b0);
        single(16'hD2A3, 3'd6, 11'h003, 1'b0);
        single(16'hA000, 3'd0, 11'h000, 1'b1);

        // Backpressure: three beats offered, two accepted
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'h2281; bus.in_pc = 16'h3200;
        step();
        bus.in_instr  = 16'h3481; bus.in_pc = 16'h3202;
        step();
        #1;
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_instr  = 16'h6681; bus.in_pc = 16'h3204;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 18; i++) step();
        chk("bp_stall_sat", 64'(stall_cnt), 64'd15);
        bus.out_ready = 1'b1;
        step();
        #1;
        chk("bp_second_head", 64'(bus.out_instr), 64'h3481);
        step();
        #1;
        chk("bp_drained", 64'(bus.out_valid), 64'd0);
        chk("bp_ready_back", 64'(bus.in_ready), 64'd1);

        // Streaming
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_instr = 16'h1020 + 16'(i);
            bus.in_pc    = 16'h4000 + 16'(2 * i);
            step();
            #1;
            chk("stream_valid", 64'(bus.out_valid), 64'd1);
            chk("stream_pc", 64'(bus.out_pc), 64'(16'h4000 + 16'(2 * i)));
            chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
        end
        bus.in_valid = 1'b0;
        step();
        #1;
        chk("stream_empty", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // Flush with count=2 and concurrent push
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h5141; bus.in_pc = 16'h5000;
        step();
        bus.in_instr = 16'h9283; bus.in_pc = 16'h5002;
        step();
        flush = 1'b1;
        bus.in_instr = 16'hE005; bus.in_pc = 16'h5004;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_empty", 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_instr = 16'hC1C0; bus.in_pc = 16'h5006;
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("flush_next_valid", 64'(bus.out_valid), 64'd1);
        chk("flush_next_instr", 64'(bus.out_instr), 64'hC1C0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Asynchronous reset between edges with count=2
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h7381; bus.in_pc = 16'h6000;
        step();
        bus.in_instr = 16'h1262; bus.in_pc = 16'h6002;
        step();
        bus.in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_stall", 64'(stall_cnt), 64'd0);
        #10 reset = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
